// File: rtl/overcooked_pkg.sv
// rtl/overcooked_pkg.sv - shared kitchen definitions for the board and pot stages
package overcooked_pkg;

   typedef enum logic [1:0] {
      RAW      = 2'd0,
      ON_BOARD = 2'd1,
      CHOPPED  = 2'd2,
      USED     = 2'd3
   } ing_state_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOADED   = 2'd1,
      CHOPPING = 2'd2,
      DONE     = 2'd3
   } board_state_t;

   localparam logic [7:0] KEY_E = 8'h08;
   localparam logic [7:0] KEY_F = 8'h09;

   localparam logic [2:0] SPR_NONE     = 3'd0;
   localparam logic [2:0] SPR_PLATE    = 3'd2;
   localparam logic [2:0] SPR_ING_BASE = 3'd3;

   localparam logic [3:0] TILE_FLOOR   = 4'd0;
   localparam logic [3:0] TILE_COUNTER = 4'd1;
   localparam logic [3:0] TILE_BOARD   = 4'd2;
   localparam logic [3:0] TILE_POT     = 4'd3;

   // Slot number of a sprite within the ingredient table; negative or >= num means not an ingredient.
   function automatic int ing_slot(input logic [2:0] spr);
      return int'(spr) - int'(SPR_ING_BASE);
   endfunction

   function automatic logic slot_valid(input int slot, input int num);
      return (slot >= 0) && (slot < num);
   endfunction

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - rising-edge pulse when keycode first becomes KEY
module key_edge_detect
   import overcooked_pkg::*;
#(
   parameter logic [7:0] KEY = KEY_E
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   output logic       keyEdge
);

   logic [7:0] prevKeycode;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset)
         prevKeycode <= 8'h00;
      else
         prevKeycode <= keycode;
   end

   assign keyEdge = (keycode == KEY) && (prevKeycode != KEY);

endmodule

// File: rtl/chop_board.sv
// rtl/chop_board.sv - cutting-board tile: place, chop for 2^CHOP_LOG2 frames, pick up
module chop_board
   import overcooked_pkg::*;
#(
   parameter int         NUM_ING    = 1,
   parameter int         CHOP_LOG2  = 7,
   parameter logic [3:0] BOARD_TILE = 4'd2
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic       wallFlag,
   input  logic [3:0] tileType,
   input  logic [2:0] heldSpriteIndex,
   input  logic       consume,
   input  logic [2:0] consumeIdx,
   output logic [1:0] objectState [NUM_ING],
   output logic [1:0] boardState,
   output logic [2:0] boardItem,
   output logic [2:0] chopProgress,
   output logic       pickupPulse
);

   board_state_t         state;
   logic [CHOP_LOG2-1:0] chopCnt;
   logic [CHOP_LOG2-1:0] cnt_inc;
   logic                 e_edge;
   logic                 f_held;
   logic                 at_board;
   logic                 empty_hand;
   logic                 held_raw;
   logic [NUM_ING-1:0]   consume_ok;
   int                   held_slot;
   int                   board_slot;
   int                   cons_slot;

   key_edge_detect #(.KEY(KEY_E)) u_e_edge (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .keycode   (keycode),
      .keyEdge   (e_edge)
   );

   assign f_held     = (keycode == KEY_F);
   assign at_board   = wallFlag && (tileType == BOARD_TILE);
   assign empty_hand = (heldSpriteIndex == SPR_NONE);
   assign cnt_inc    = chopCnt + 1'b1;
   assign held_slot  = ing_slot(heldSpriteIndex);
   assign board_slot = ing_slot(boardItem);
   assign cons_slot  = ing_slot(consumeIdx);
   assign boardState = state;

   always_comb begin
      held_raw = 1'b0;
      for (int i = 0; i < NUM_ING; i++) begin
         if (held_slot == i && objectState[i] == RAW)
            held_raw = 1'b1;
      end
   end

   // The item sitting on a busy board is never consumable, even once chopped.
   always_comb begin
      consume_ok = '0;
      for (int i = 0; i < NUM_ING; i++) begin
         consume_ok[i] = consume && (cons_slot == i) && (objectState[i] == CHOPPED)
                         && !((state != IDLE) && (board_slot == i));
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         boardItem    <= SPR_NONE;
         chopCnt      <= '0;
         chopProgress <= 3'd0;
         pickupPulse  <= 1'b0;
         for (int i = 0; i < NUM_ING; i++)
            objectState[i] <= RAW;
      end else begin
         pickupPulse <= 1'b0;
         for (int i = 0; i < NUM_ING; i++) begin
            if (consume_ok[i])
               objectState[i] <= USED;
         end

         case (state)
            IDLE: begin
               if (e_edge && at_board && slot_valid(held_slot, NUM_ING) && held_raw) begin
                  state        <= LOADED;
                  boardItem    <= heldSpriteIndex;
                  chopCnt      <= '0;
                  chopProgress <= 3'd0;
                  for (int i = 0; i < NUM_ING; i++) begin
                     if (held_slot == i)
                        objectState[i] <= ON_BOARD;
                  end
               end
            end

            LOADED, CHOPPING: begin
               if (e_edge && at_board && empty_hand) begin
                  state        <= IDLE;
                  boardItem    <= SPR_NONE;
                  chopCnt      <= '0;
                  chopProgress <= 3'd0;
                  for (int i = 0; i < NUM_ING; i++) begin
                     if (board_slot == i)
                        objectState[i] <= RAW;
                  end
               end else if (f_held && at_board) begin
                  if (chopCnt == {CHOP_LOG2{1'b1}}) begin
                     state        <= DONE;
                     chopCnt      <= '0;
                     chopProgress <= 3'd7;
                     for (int i = 0; i < NUM_ING; i++) begin
                        if (board_slot == i)
                           objectState[i] <= CHOPPED;
                     end
                  end else begin
                     state        <= CHOPPING;
                     chopCnt      <= cnt_inc;
                     chopProgress <= cnt_inc[CHOP_LOG2-1 -: 3];
                  end
               end
            end

            DONE: begin
               if (e_edge && at_board && empty_hand) begin
                  state        <= IDLE;
                  boardItem    <= SPR_NONE;
                  chopProgress <= 3'd0;
                  pickupPulse  <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chop_board.sv
// tb/tb_chop_board.sv - table-driven scoreboard bench for chop_board
module tb_chop_board;
   import overcooked_pkg::*;

   typedef struct {
      logic [7:0] key;
      logic       wall;
      logic [3:0] tile;
      logic [2:0] held;
      logic       cons;
      logic [2:0] cidx;
      logic [1:0] st;
      logic [2:0] item;
      logic [2:0] prog;
      logic [1:0] obj;
      logic       pulse;
   } vec_t;

   typedef struct {
      logic [1:0] st;
      logic [2:0] item;
      logic [2:0] prog;
      logic [1:0] obj;
      logic       pulse;
   } exp_t;

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] keycode = 8'h00;
   logic       wallFlag = 1'b0;
   logic [3:0] tileType = 4'd0;
   logic [2:0] heldSpriteIndex = 3'd0;
   logic       consume = 1'b0;
   logic [2:0] consumeIdx = 3'd0;
   logic [1:0] objectState [1];
   logic [1:0] boardState;
   logic [2:0] boardItem;
   logic [2:0] chopProgress;
   logic       pickupPulse;

   int   total = 0;
   int   bad = 0;
   exp_t sb_q[$];

   chop_board #(.NUM_ING(1), .CHOP_LOG2(7), .BOARD_TILE(4'd2)) dut (
      .frame_clk       (frame_clk),
      .Reset           (Reset),
      .keycode         (keycode),
      .wallFlag        (wallFlag),
      .tileType        (tileType),
      .heldSpriteIndex (heldSpriteIndex),
      .consume         (consume),
      .consumeIdx      (consumeIdx),
      .objectState     (objectState),
      .boardState      (boardState),
      .boardItem       (boardItem),
      .chopProgress    (chopProgress),
      .pickupPulse     (pickupPulse)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] key, input logic wall, input logic [3:0] tile,
                               input logic [2:0] held, input logic cons, input logic [2:0] cidx,
                               input logic [1:0] st, input logic [2:0] item, input logic [2:0] prog,
                               input logic [1:0] obj, input logic pulse);
      vec_t v;
      v.key = key; v.wall = wall; v.tile = tile; v.held = held; v.cons = cons; v.cidx = cidx;
      v.st = st; v.item = item; v.prog = prog; v.obj = obj; v.pulse = pulse;
      return v;
   endfunction

   task automatic step(input vec_t v, input string tag);
      exp_t e;
      exp_t got;
      keycode = v.key; wallFlag = v.wall; tileType = v.tile;
      heldSpriteIndex = v.held; consume = v.cons; consumeIdx = v.cidx;
      e.st = v.st; e.item = v.item; e.prog = v.prog; e.obj = v.obj; e.pulse = v.pulse;
      sb_q.push_back(e);
      @(posedge frame_clk);
      #1;
      got = sb_q.pop_front();
      chk({tag, ".boardState"}, int'(boardState), int'(got.st));
      chk({tag, ".boardItem"}, int'(boardItem), int'(got.item));
      chk({tag, ".chopProgress"}, int'(chopProgress), int'(got.prog));
      chk({tag, ".objectState0"}, int'(objectState[0]), int'(got.obj));
      chk({tag, ".pickupPulse"}, int'(pickupPulse), int'(got.pulse));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, ".boardState"}, int'(boardState), 0);
      chk({tag, ".boardItem"}, int'(boardItem), 0);
      chk({tag, ".chopProgress"}, int'(chopProgress), 0);
      chk({tag, ".objectState0"}, int'(objectState[0]), 0);
      chk({tag, ".pickupPulse"}, int'(pickupPulse), 0);
      chk({tag, ".chopCnt"}, int'(dut.chopCnt), 0);
   endtask

   task automatic do_reset(input string tag);
      keycode = 8'h00; wallFlag = 1'b0; tileType = 4'd0;
      heldSpriteIndex = 3'd0; consume = 1'b0; consumeIdx = 3'd0;
      @(posedge frame_clk);
      #1;
      Reset = 1'b1;
      #1;
      check_reset_values(tag);
      @(posedge frame_clk);
      #1;
      Reset = 1'b0;
   endtask

   // F held at the board; expected progress follows the running count of held frames.
   task automatic chop_frames(input int first, input int last, input string tag);
      for (int k = first; k <= last; k++) begin
         if (k == 128)
            step(mk(8'h09, 1, 4'd2, 3'd3, 0, 3'd0, 2'd3, 3'd3, 3'd7, 2'd2, 0), tag);
         else
            step(mk(8'h09, 1, 4'd2, 3'd3, 0, 3'd0, 2'd2, 3'd3, 3'(k >> 4), 2'd1, 0), tag);
      end
   endtask

   vec_t pre_tbl [12];
   vec_t post_tbl [8];

   initial begin
      pre_tbl[0]  = mk(8'h08, 0, 4'd2, 3'd3, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0);
      pre_tbl[1]  = mk(8'h00, 1, 4'd2, 3'd3, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0);
      pre_tbl[2]  = mk(8'h08, 1, 4'd5, 3'd3, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0);
      pre_tbl[3]  = mk(8'h00, 1, 4'd2, 3'd3, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0);
      pre_tbl[4]  = mk(8'h08, 1, 4'd2, 3'd2, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0);
      pre_tbl[5]  = mk(8'h08, 1, 4'd2, 3'd3, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0);
      pre_tbl[6]  = mk(8'h00, 1, 4'd2, 3'd3, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0);
      pre_tbl[7]  = mk(8'h08, 1, 4'd2, 3'd3, 0, 3'd0, 2'd1, 3'd3, 3'd0, 2'd1, 0);
      pre_tbl[8]  = mk(8'h08, 1, 4'd2, 3'd3, 0, 3'd0, 2'd1, 3'd3, 3'd0, 2'd1, 0);
      pre_tbl[9]  = mk(8'h09, 0, 4'd2, 3'd3, 0, 3'd0, 2'd1, 3'd3, 3'd0, 2'd1, 0);
      pre_tbl[10] = mk(8'h00, 1, 4'd2, 3'd3, 1, 3'd3, 2'd1, 3'd3, 3'd0, 2'd1, 0);
      pre_tbl[11] = mk(8'h09, 1, 4'd7, 3'd3, 0, 3'd0, 2'd1, 3'd3, 3'd0, 2'd1, 0);

      post_tbl[0] = mk(8'h09, 1, 4'd2, 3'd0, 0, 3'd0, 2'd3, 3'd3, 3'd7, 2'd2, 0);
      post_tbl[1] = mk(8'h08, 1, 4'd2, 3'd3, 0, 3'd0, 2'd3, 3'd3, 3'd7, 2'd2, 0);
      post_tbl[2] = mk(8'h00, 1, 4'd2, 3'd0, 1, 3'd3, 2'd3, 3'd3, 3'd7, 2'd2, 0);
      post_tbl[3] = mk(8'h08, 1, 4'd2, 3'd0, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd2, 1);
      post_tbl[4] = mk(8'h08, 1, 4'd2, 3'd0, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd2, 0);
      post_tbl[5] = mk(8'h00, 1, 4'd2, 3'd0, 1, 3'd3, 2'd0, 3'd0, 3'd0, 2'd3, 0);
      post_tbl[6] = mk(8'h00, 1, 4'd2, 3'd0, 1, 3'd3, 2'd0, 3'd0, 3'd0, 2'd3, 0);
      post_tbl[7] = mk(8'h08, 1, 4'd2, 3'd3, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd3, 0);

      #2;
      check_reset_values("reset");
      @(posedge frame_clk);
      #1;
      Reset = 1'b0;

      for (int i = 0; i < 12; i++)
         step(pre_tbl[i], $sformatf("pre%0d", i));

      chop_frames(1, 40, "chop_a");
      for (int i = 0; i < 20; i++)
         step(mk(8'h00, 1, 4'd2, 3'd3, 0, 3'd0, 2'd2, 3'd3, 3'd2, 2'd1, 0), "pause");
      chk("pause.chopCnt", int'(dut.chopCnt), 40);
      chop_frames(41, 128, "chop_b");
      chk("done.chopCnt", int'(dut.chopCnt), 0);

      for (int i = 0; i < 8; i++)
         step(post_tbl[i], $sformatf("post%0d", i));

      do_reset("reset2");
      step(mk(8'h08, 1, 4'd2, 3'd3, 0, 3'd0, 2'd1, 3'd3, 3'd0, 2'd1, 0), "place2");
      chop_frames(1, 50, "chop_c");
      chk("abandon.pre_chopCnt", int'(dut.chopCnt), 50);
      step(mk(8'h08, 1, 4'd2, 3'd0, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0), "abandon");
      chk("abandon.chopCnt", int'(dut.chopCnt), 0);

      step(mk(8'h00, 1, 4'd2, 3'd3, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0), "release3");
      step(mk(8'h08, 1, 4'd2, 3'd3, 0, 3'd0, 2'd1, 3'd3, 3'd0, 2'd1, 0), "place3");
      chop_frames(1, 100, "chop_d");
      chk("midreset.pre_chopCnt", int'(dut.chopCnt), 100);
      #2;
      Reset = 1'b1;
      #1;
      check_reset_values("midreset");
      @(posedge frame_clk);
      #1;
      Reset = 1'b0;
      step(mk(8'h00, 1, 4'd2, 3'd3, 0, 3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 0), "after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chop_board.md
Name: chop_board

Overview:
- Upstream feeder for the cooking pot stage.
- Owns the cutting-board tile. A player places a raw ingredient on it, holds the chop key for a fixed number of frames, then picks the chopped ingredient back up.
- Publishes per-ingredient state (RAW/ON_BOARD/CHOPPED/USED); the pot reads CHOPPED (2) before accepting an ingredient.
- Drives a 3-bit progress value for the HUD progress-bar sprite.

Parameters:
- NUM_ING, 1, number of ingredient objects tracked (sprite indices SPR_ING_BASE..SPR_ING_BASE+NUM_ING-1)
- CHOP_LOG2, 7, chop time = 2^CHOP_LOG2 frames (128 frames ≈ 2.1 s at 60 Hz); must be ≥ 3
- BOARD_TILE, 4'd2, tileType code of the cutting board

Ports:
- frame_clk  input  1  clock, vsync-rate
- Reset  input  1  asynchronous, active-high
- keycode  input  8  current USB HID keycode
- wallFlag  input  1  player is facing an interactable tile
- tileType  input  4  type of the faced tile
- heldSpriteIndex  input  3  player's held sprite (0 none, 2 plate, ≥SPR_ING_BASE ingredient)
- consume  input  1  one-frame pulse from the pot: a held chopped ingredient went into the pot
- consumeIdx  input  3  sprite index of the consumed ingredient
- objectState  output  2 x [NUM_ING]  per-ingredient state, unpacked array
- boardState  output  2  IDLE=0, LOADED=1, CHOPPING=2, DONE=3
- boardItem  output  3  sprite index currently on the board (0 if none)
- chopProgress  output  3  progress bar level 0..7
- pickupPulse  output  1  one-frame pulse when the player takes a chopped item off the board

Behaviour:
- Reset values: objectState all RAW, boardState IDLE, boardItem 0, chopCnt 0, chopProgress 0, pickupPulse 0, prevKeycode 0.
- All state updates on posedge frame_clk. One frame of latency from inputs to outputs.
- Definitions:
  - at_board = wallFlag && tileType==BOARD_TILE
  - eEdge = keycode==8'h08 && prevKeycode!=8'h08
  - fHeld = keycode==8'h09 (level)
  - prevKeycode <= keycode every frame.
- IDLE:
  - Condition: eEdge && at_board && held index is an ingredient && that ingredient's objectState==RAW.
  - Action: go to LOADED, boardItem <= held index, objectState[held-SPR_ING_BASE] <= ON_BOARD, chopCnt <= 0.
  - Any other input leaves IDLE unchanged.
- LOADED / CHOPPING, evaluated in priority order:
  1. eEdge && at_board && heldSpriteIndex==0: abandon. IDLE, item -> RAW, boardItem 0, chopCnt 0.
  2. fHeld && at_board: chopCnt++ and boardState <= CHOPPING. When chopCnt == 2^CHOP_LOG2-1 with fHeld, go instead to DONE, item -> CHOPPED, chopCnt <= 0.
  3. Otherwise (F released or player walks away): hold state and chopCnt. Chopping pauses; it does not reset.
- DONE:
  - Condition: eEdge && at_board && heldSpriteIndex==0.
  - Action: go to IDLE, boardItem <= 0, pickupPulse <= 1 for one frame. objectState stays CHOPPED.
  - Any other input holds DONE.
- chopProgress = chopCnt[CHOP_LOG2-1 -: 3] in LOADED/CHOPPING; 7 in DONE; 0 in IDLE. Registered with the state.
- chopCnt is CHOP_LOG2 bits wide. It never wraps, because the terminal count forces the transition to DONE.
- consume:
  - When consume=1 and objectState[consumeIdx-SPR_ING_BASE]==CHOPPED, that item goes to USED.
  - Ignored if consumeIdx is out of ingredient range or the item is not CHOPPED.
  - Ignored if the item is boardItem while boardState != IDLE.
  - A consume on a different index in the same frame as a board transition applies both updates.
- USED is terminal until Reset. No respawn in this block.
- E edge has priority over F when both are seen in one frame (the keycode can only hold one value, but the priority is stated for robustness).
- Reset asserted mid-chop returns everything to reset values immediately (asynchronous).

Decomposition:
- overcooked_pkg holds the shared definitions:
  - ing_state_t enum (RAW, ON_BOARD, CHOPPED, USED)
  - board_state_t enum
  - KEY_E=8'h08, KEY_F=8'h09
  - SPR_NONE=0, SPR_PLATE=2, SPR_ING_BASE=3
  - tile codes
- The pot stage imports the same package.
- One sub-module, key_edge_detect (parameter KEY). It registers the previous keycode and outputs a rising-edge pulse. It is instantiated for KEY_E here and is reusable by the pot.

Test Plan:
- Place and chop:
  - Stimulus: hold sprite 3 at board, E edge, then F held for 128 frames.
  - Required: boardState 1 then 2. chopProgress steps every 16 frames. At frame 128 boardState=3, objectState[0]=2, chopProgress=7.
- Pause:
  - Stimulus: F held 40 frames, released 20 frames, held 88 frames.
  - Required: chopCnt holds at 40 during the release. DONE is reached after 128 held frames in total.
- Abandon:
  - Stimulus: E edge with hands empty mid-chop at chopCnt=50.
  - Required: IDLE, objectState[0]=RAW, chopCnt=0, boardItem=0.
- Pickup and consume:
  - Stimulus: E edge empty-handed in DONE, then a consume pulse with consumeIdx=3.
  - Required: pickupPulse high for exactly 1 frame. objectState[0]: 2 then 3. A second consume leaves it at 3.
- Illegal inputs:
  - Stimulus: E held continuously (no new edge), plate held (index 2), or wallFlag=0 / wrong tileType.
  - Required: no state change.
- Reset mid-chop:
  - Stimulus: Reset asserted at chopCnt=100, asynchronous to the clock.
  - Required: all outputs return to reset values before the next frame_clk edge.
